axis_fifo_frame_writer: RTL and testbench
=========================================

Name: axis_fifo_frame_writer

Overview:
Write-side producer for the 16-bit async FIFO, running entirely in the wr_clk domain.
- Accepts an AXI-Stream packet and frames it into FIFO words: header, payload, length trailer, optional checksum trailer.
- Drives the FIFO write port and throttles on fifo_afull.
- The read-clock consumer delimits and validates frames from the header and trailer words.

Parameters:
MAX_LEN, 1024, maximum payload words per frame; legal range 1..32767; longer packets are truncated.
HDR_TAG, 8'hA5, upper byte of every header word.

Ports:
wr_clk  in  1  write-domain clock
resetn  in  1  synchronous active-low reset
s_axis_tdata  in  16  payload beat
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  last beat of packet
s_axis_tready  out  1  beat accepted when tvalid&tready
fifo_afull  in  1  FIFO almost-full; no new write is issued while high
fifo_wr_en  out  1  registered FIFO write strobe
fifo_wr_data  out  16  registered FIFO write data
frame_done  out  1  one-cycle pulse on the cycle the final trailer write is issued
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (resetn=0 at a wr_clk edge):
  - State goes to IDLE.
  - fifo_wr_en=0, fifo_wr_data=0, frame_done=0, busy=0.
  - seq, count, csum and trunc all clear to 0.
- Reset mid-frame abandons the partial frame; no trailer is written.
- The next frame after reset uses seq 0.

All outputs except s_axis_tready are registered. fifo_wr_en/fifo_wr_data appear one cycle after the decision cycle. fifo_wr_en is 0 in any cycle with no decision.

States: IDLE, DATA, TRL_LEN, TRL_CSUM, DROP.
- IDLE:
  - s_axis_tready=0.
  - If tvalid && !fifo_afull: write header {HDR_TAG, seq[7:0]}, clear count/csum/trunc, go to DATA.
- DATA:
  - s_axis_tready = !fifo_afull (combinational).
  - On accept: write tdata, count+=1, csum ^= tdata.
  - If tlast: go to TRL_LEN.
  - Else if the new count == MAX_LEN: set trunc, go to TRL_LEN.
- TRL_LEN:
  - s_axis_tready=0.
  - When !fifo_afull: write {trunc, count[14:0]}.
  - Next state is TRL_CSUM if CHECKSUM_EN is defined; otherwise the frame-end step below.
- TRL_CSUM:
  - s_axis_tready=0.
  - When !fifo_afull: write csum, then the frame-end step.
- Frame-end step:
  - frame_done is registered high for one cycle.
  - seq increments modulo 256.
  - Next state is DROP if trunc, else IDLE.
- DROP:
  - s_axis_tready=1; accepted beats are discarded with no FIFO write.
  - On an accepted beat with tlast: go to IDLE.
- fifo_afull rules:
  - It gates only the issue of a new write; an already-registered write always completes.
  - fifo_afull=1 for any duration means no data loss and no duplicate writes.
- Packet length boundaries:
  - A packet of exactly MAX_LEN beats with tlast on the last beat has trunc=0 and no DROP.
  - A single-beat packet gives count=1.
- Widths:
  - count is 15 bits.
  - csum is the 16-bit XOR of payload words written, seeded with 0; dropped beats are not included.
- Throughput: back-to-back frames have one IDLE cycle plus the trailer cycles between payloads.

Optional Feature:
CHECKSUM_EN
- Defined: the TRL_CSUM state exists; every frame ends with length word then checksum word. Frame size = payload + 3 words.
- Undefined: TRL_CSUM is absent and the csum register is not built. TRL_LEN goes directly to the frame-end step. Frame size = payload + 2 words.

Test Plan:
1. Reset -> all registered outputs 0 and s_axis_tready=0. Then 3-beat packet 0x0001,0x0002,0x0004 (tlast on 3rd), afull=0, CHECKSUM_EN -> FIFO writes 0xA500,0x0001,0x0002,0x0004,0x0003,0x0007; frame_done pulses once; busy low afterwards.
2. Second identical packet -> header 0xA501. Run 256 frames -> headers wrap 0xA5FF then 0xA500.
3. fifo_afull held high for 5 cycles mid-payload -> s_axis_tready=0 and fifo_wr_en=0 throughout; the payload resumes with no loss or duplication. afull during TRL_LEN delays the trailer correctly.
4. MAX_LEN=4, 6-beat packet 0x0010..0x0015 -> writes 0xA500,0x0010,0x0011,0x0012,0x0013,0x8004,0x0000. Beats 0x0014/0x0015 accepted with tready=1 and no write; IDLE after the tlast beat.
5. resetn pulsed low after 2 payload beats -> no trailer written; the next packet's header is 0xA500 and its length word counts only the new payload.
6. CHECKSUM_EN undefined, packet as in scenario 1 -> writes 0xA500,0x0001,0x0002,0x0004,0x0003; frame_done on the length-word cycle.

Source files
------------

// File: rtl/axis_fifo_frame_writer.sv
// axis_fifo_frame_writer: frames AXI-Stream packets into header/payload/trailer words for the async FIFO write port.
// Define CHECKSUM_EN to append an XOR checksum word after the length trailer.
module axis_fifo_frame_writer #(
    parameter int          MAX_LEN = 1024,
    parameter logic [7:0]  HDR_TAG = 8'hA5
) (
    input  logic        wr_clk,
    input  logic        resetn,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    input  logic        fifo_afull,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_wr_data,
    output logic        frame_done,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DATA     = 3'd1,
        TRL_LEN  = 3'd2,
`ifdef CHECKSUM_EN
        TRL_CSUM = 3'd4,
`endif
        DROP     = 3'd3
    } state_t;

    state_t      state, state_n, end_state;
    logic [7:0]  seq;
    logic [14:0] count, count_n, count_inc;
    logic        trunc, trunc_n, wr_n, done_n, accept;
    logic [15:0] data_n;
`ifdef CHECKSUM_EN
    logic [15:0] csum, csum_n;
`endif

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign count_inc = count + 15'd1;
    assign end_state = trunc ? DROP : IDLE;

    always_ff @(posedge wr_clk) begin
        if (!resetn) begin
            state        <= IDLE;
            seq          <= 8'd0;
            count        <= 15'd0;
            trunc        <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= 16'd0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
`ifdef CHECKSUM_EN
            csum         <= 16'd0;
`endif
        end else begin
            state        <= state_n;
            seq          <= seq + 8'(done_n);
            count        <= count_n;
            trunc        <= trunc_n;
            fifo_wr_en   <= wr_n;
            fifo_wr_data <= data_n;
            frame_done   <= done_n;
            busy         <= state_n != IDLE;
`ifdef CHECKSUM_EN
            csum         <= csum_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (s_axis_tvalid && !fifo_afull) state_n = DATA;
            DATA:     if (accept && (s_axis_tlast || count_inc == 15'(MAX_LEN))) state_n = TRL_LEN;
`ifdef CHECKSUM_EN
            TRL_LEN:  if (!fifo_afull) state_n = TRL_CSUM;
            TRL_CSUM: if (!fifo_afull) state_n = end_state;
`else
            TRL_LEN:  if (!fifo_afull) state_n = end_state;
`endif
            DROP:     if (accept && s_axis_tlast) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // afull only gates issuing a new write; registered writes always land
    always_comb begin
        s_axis_tready = (state == DATA && !fifo_afull) || state == DROP;
        wr_n    = 1'b0;
        data_n  = 16'd0;
        done_n  = 1'b0;
        count_n = count;
        trunc_n = trunc;
`ifdef CHECKSUM_EN
        csum_n  = csum;
`endif
        case (state)
            IDLE: if (s_axis_tvalid && !fifo_afull) begin
                wr_n    = 1'b1;
                data_n  = {HDR_TAG, seq};
                count_n = 15'd0;
                trunc_n = 1'b0;
`ifdef CHECKSUM_EN
                csum_n  = 16'd0;
`endif
            end
            DATA: if (accept) begin
                wr_n    = 1'b1;
                data_n  = s_axis_tdata;
                count_n = count_inc;
                trunc_n = !s_axis_tlast && count_inc == 15'(MAX_LEN);
`ifdef CHECKSUM_EN
                csum_n  = csum ^ s_axis_tdata;
`endif
            end
            TRL_LEN: if (!fifo_afull) begin
                wr_n   = 1'b1;
                data_n = {trunc, count};
`ifndef CHECKSUM_EN
                done_n = 1'b1;
`endif
            end
`ifdef CHECKSUM_EN
            TRL_CSUM: if (!fifo_afull) begin
                wr_n   = 1'b1;
                data_n = csum;
                done_n = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axis_fifo_frame_writer.sv
// tb_axis_fifo_frame_writer: scoreboard bench; expected FIFO words are queued per packet and popped on each write.
// Follows CHECKSUM_EN the same way as the design.
module tb_axis_fifo_frame_writer;
    localparam int MAX_LEN = 4;

    logic        wr_clk = 0;
    logic        resetn;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        fifo_afull;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int errs = 0;
    logic [16:0] q[$];
    logic [15:0] pkt[$];
    logic [7:0]  seq_m = 8'd0;

    axis_fifo_frame_writer #(.MAX_LEN(MAX_LEN), .HDR_TAG(8'hA5)) dut (
        .wr_clk(wr_clk),
        .resetn(resetn),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .fifo_afull(fifo_afull),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .frame_done(frame_done),
        .busy(busy)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // scoreboard entries are {frame_done, word}
    always @(negedge wr_clk) begin
        if (frame_done) chk("done_with_wr", 32'(fifo_wr_en), 1);
        if (fifo_wr_en) begin
            if (q.size() == 0) chk("wr_expected", 32'(q.size()), 1);
            else chk("wr_word", 32'({frame_done, fifo_wr_data}), 32'(q.pop_front()));
        end
    end

    task automatic expect_frame();
        int n;
        logic [15:0] cs;
        logic        tr;
        n  = pkt.size() > MAX_LEN ? MAX_LEN : pkt.size();
        tr = pkt.size() > MAX_LEN;
        cs = 16'd0;
        q.push_back({1'b0, 8'hA5, seq_m});
        for (int i = 0; i < n; i++) begin
            q.push_back({1'b0, pkt[i]});
            cs ^= pkt[i];
        end
`ifdef CHECKSUM_EN
        q.push_back({1'b0, tr, 15'(n)});
        q.push_back({1'b1, cs});
`else
        q.push_back({1'b1, tr, 15'(n)});
`endif
        seq_m++;
    endtask

    task automatic beat(input logic [15:0] d, input bit last);
        bit acc;
        int t;
        s_axis_tvalid = 1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        acc = 0;
        t = 0;
        while (!acc && t < 50) begin
            @(negedge wr_clk);
            acc = s_axis_tready;
            @(posedge wr_clk);
            #1;
            t++;
        end
        chk("beat_accept", 32'(acc), 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge wr_clk);
        chk("drain", 32'(q.size()), 0);
    endtask

    task automatic send(input int stall_at, input bit trl_stall);
        expect_frame();
        for (int i = 0; i < pkt.size(); i++) begin
            if (i == stall_at) begin
                s_axis_tvalid = 1;
                s_axis_tdata  = pkt[i];
                s_axis_tlast  = i == pkt.size() - 1;
                fifo_afull    = 1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge wr_clk);
                    chk("stall_tready", 32'(s_axis_tready), 0);
                    if (k > 0) chk("stall_wr", 32'(fifo_wr_en), 0);
                    @(posedge wr_clk);
                    #1;
                end
                fifo_afull = 0;
            end
            beat(pkt[i], i == pkt.size() - 1);
        end
        s_axis_tvalid = 0;
        s_axis_tlast  = 0;
        if (trl_stall) begin
            fifo_afull = 1;
            for (int k = 0; k < 4; k++) begin
                @(negedge wr_clk);
                chk("trl_busy", 32'(busy), 1);
                if (k > 0) chk("trl_stall_wr", 32'(fifo_wr_en), 0);
                @(posedge wr_clk);
                #1;
            end
            fifo_afull = 0;
        end
        drain();
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0;
        fifo_afull = 0;
        s_axis_tvalid = 0;
        s_axis_tlast = 0;
        s_axis_tdata = 16'd0;
        repeat (3) @(posedge wr_clk);
        @(negedge wr_clk);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_wr_data", 32'(fifo_wr_data), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tready", 32'(s_axis_tready), 0);
        @(posedge wr_clk);
        #1;
        resetn = 1;

        pkt = '{16'h0001, 16'h0002, 16'h0004};
        send(-1, 0);
        send(-1, 0);
        for (int f = 0; f < 256; f++) begin
            pkt.delete();
            pkt.push_back(16'($urandom));
            send(-1, 0);
        end
        pkt = '{16'h1111, 16'h2222, 16'h4444, 16'h8888};
        send(-1, 0);
        pkt = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        send(2, 0);
        pkt = '{16'h0a0a, 16'h0b0b};
        send(-1, 1);
        pkt = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015};
        send(-1, 0);
        pkt = '{16'h0020};
        send(-1, 0);

        q.push_back({1'b0, 8'hA5, seq_m});
        q.push_back({1'b0, 16'h0030});
        q.push_back({1'b0, 16'h0031});
        beat(16'h0030, 0);
        beat(16'h0031, 0);
        s_axis_tvalid = 0;
        @(negedge wr_clk);
        @(posedge wr_clk);
        #1;
        resetn = 0;
        @(posedge wr_clk);
        @(negedge wr_clk);
        chk("mid_rst_wr_en", 32'(fifo_wr_en), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_tready", 32'(s_axis_tready), 0);
        chk("mid_rst_queue", 32'(q.size()), 0);
        resetn = 1;
        seq_m = 8'd0;
        repeat (3) @(negedge wr_clk);
        chk("no_trailer", 32'(q.size()), 0);
        @(posedge wr_clk);
        #1;
        pkt = '{16'h0040, 16'h0041};
        send(-1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end
endmodule
